// File: rtl/pipeline_ctrl_if.sv
// pipeline_ctrl_if
//   Groups the handshake between the pipeline datapath and its hazard/run
//   controller.
//   master : the datapath side. It drives the run controls and the hazard
//            inputs, and it receives the stage enables.
//   slave  : the controller side (pipeline_ctrl).
//   Inputs to the controller : i_run_mode, i_start, i_step, i_ifid_rs,
//                              i_ifid_rt, i_idex_rt, i_idex_memread,
//                              i_branch_taken, i_halt_id
//   Outputs of the controller: o_pipe_enable, o_pc_write, o_ifid_write,
//                              o_ifid_flush, o_idex_bubble, o_state,
//                              o_halted, o_cycle_count
interface pipeline_ctrl_if #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CYCLE_WIDTH    = 32
);
  logic                      i_run_mode;
  logic                      i_start;
  logic                      i_step;
  logic [REG_ADDR_WIDTH-1:0] i_ifid_rs;
  logic [REG_ADDR_WIDTH-1:0] i_ifid_rt;
  logic [REG_ADDR_WIDTH-1:0] i_idex_rt;
  logic                      i_idex_memread;
  logic                      i_branch_taken;
  logic                      i_halt_id;

  logic                      o_pipe_enable;
  logic                      o_pc_write;
  logic                      o_ifid_write;
  logic                      o_ifid_flush;
  logic                      o_idex_bubble;
  logic [2:0]                o_state;
  logic                      o_halted;
  logic [CYCLE_WIDTH-1:0]    o_cycle_count;

  modport master (
    output i_run_mode, i_start, i_step, i_ifid_rs, i_ifid_rt, i_idex_rt,
           i_idex_memread, i_branch_taken, i_halt_id,
    input  o_pipe_enable, o_pc_write, o_ifid_write, o_ifid_flush,
           o_idex_bubble, o_state, o_halted, o_cycle_count
  );

  modport slave (
    input  i_run_mode, i_start, i_step, i_ifid_rs, i_ifid_rt, i_idex_rt,
           i_idex_memread, i_branch_taken, i_halt_id,
    output o_pipe_enable, o_pc_write, o_ifid_write, o_ifid_flush,
           o_idex_bubble, o_state, o_halted, o_cycle_count
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl
//   Run/step controller and hazard unit for a 5-stage pipeline.
//   The controller sequences IDLE -> RUN or STEP -> DRAIN -> DONE. It
//   generates the global stage enable, which is either continuous or one
//   cycle per step edge. It resolves load-use stalls, branch flushes and
//   HALT, and it counts enabled cycles.
//   Ports:
//     i_clock : clock. All state updates on the rising edge.
//     i_reset : asynchronous reset, active low.
//     bus     : pipeline_ctrl_if.slave, which carries the run controls, the
//               hazard inputs, the stage enables, the state, the halted flag
//               and the cycle count.
//   Only the state, the drain counter, the step-edge register, the captured
//   mode and the cycle counter are registered. The stage controls are
//   combinational from the state and the inputs.
module pipeline_ctrl #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CYCLE_WIDTH    = 32
) (
  input  logic             i_clock,
  input  logic             i_reset,
  pipeline_ctrl_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'b000,
    RUN   = 3'b001,
    STEP  = 3'b010,
    DRAIN = 3'b011,
    DONE  = 3'b100
  } state_t;

  state_t                 state_reg;
  logic [1:0]             drain_cnt_reg;
  logic                   step_prev_reg;
  logic                   run_mode_reg;  // mode latched on start, reused by DRAIN
  logic [CYCLE_WIDTH-1:0] cycle_count_reg;

  logic [REG_ADDR_WIDTH-1:0] idex_rt;
  logic step_rise;
  logic hazard;
  logic pipe_en;
  logic pc_write;
  logic ifid_write;
  logic ifid_flush;
  logic idex_bubble;

  assign idex_rt = bus.i_idex_rt;

  always_comb begin
    step_rise = bus.i_step & ~step_prev_reg;
    // Register 0 is hard-wired, so a load into it never creates a hazard.
    hazard = bus.i_idex_memread & (idex_rt != '0) &
             ((idex_rt == bus.i_ifid_rs) | (idex_rt == bus.i_ifid_rt));

    pipe_en = 1'b0;
    case (state_reg)
      RUN:     pipe_en = 1'b1;
      STEP:    pipe_en = step_rise;
      DRAIN:   pipe_en = run_mode_reg ? 1'b1 : step_rise;
      default: pipe_en = 1'b0;
    endcase

    pc_write    = 1'b0;
    ifid_write  = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    if (pipe_en) begin
      if (state_reg == DRAIN) begin
        // Fetch is frozen and zeros are fed behind the HALT.
        idex_bubble = 1'b1;
      end else if (hazard) begin
        // A stall wins. Branch and halt are seen again once the load moves on.
        idex_bubble = 1'b1;
      end else if (bus.i_halt_id) begin
        // Freeze PC and IF/ID. The HALT itself continues down the pipe.
      end else if (bus.i_branch_taken) begin
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        ifid_flush = 1'b1;
      end else begin
        pc_write   = 1'b1;
        ifid_write = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_reg       <= IDLE;
      drain_cnt_reg   <= 2'd0;
      step_prev_reg   <= 1'b0;
      run_mode_reg    <= 1'b0;
      cycle_count_reg <= '0;
    end else begin
      step_prev_reg <= bus.i_step;

      if (pipe_en && (cycle_count_reg != {CYCLE_WIDTH{1'b1}}))
        cycle_count_reg <= cycle_count_reg + 1'b1;

      case (state_reg)
        IDLE: begin
          if (bus.i_start) begin
            run_mode_reg <= bus.i_run_mode;
            state_reg    <= bus.i_run_mode ? RUN : STEP;
          end
        end
        RUN, STEP: begin
          if (pipe_en && !hazard && bus.i_halt_id) begin
            state_reg     <= DRAIN;
            drain_cnt_reg <= 2'd3;
          end
        end
        DRAIN: begin
          if (pipe_en) begin
            drain_cnt_reg <= drain_cnt_reg - 2'd1;
            if (drain_cnt_reg == 2'd1)
              state_reg <= DONE;
          end
        end
        default: state_reg <= DONE;  // DONE is held until reset
      endcase
    end
  end

  assign bus.o_pipe_enable = pipe_en;
  assign bus.o_pc_write    = pc_write;
  assign bus.o_ifid_write  = ifid_write;
  assign bus.o_ifid_flush  = ifid_flush;
  assign bus.o_idex_bubble = idex_bubble;
  assign bus.o_state       = state_reg;
  assign bus.o_halted      = (state_reg == DONE);
  assign bus.o_cycle_count = cycle_count_reg;

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 Parameter REG_ADDR_WIDTH, default 5, register-specifier width.
REQ-002 Parameter CYCLE_WIDTH, default 32, cycle-counter width.
REQ-003 i_clock  in  1  sole clock; all state updates on posedge.
REQ-004 i_reset  in  1  asynchronous, active-low reset; 0 resets immediately, independent of i_clock.
REQ-005 i_run_mode  in  1  1 = continuous run, 0 = single-step; sampled only in IDLE on i_start.
REQ-006 i_start  in  1  level; leaves IDLE.
REQ-007 i_step  in  1  step request; rising edge detected internally.
REQ-008 i_ifid_rs, i_ifid_rt  in  REG_ADDR_WIDTH  source registers of instruction in IF/ID.
REQ-009 i_idex_rt  in  REG_ADDR_WIDTH  destination of instruction in ID/EX.
REQ-010 i_idex_memread  in  1  ID/EX instruction is a load.
REQ-011 i_branch_taken  in  1  branch/jump in ID resolved taken this cycle.
REQ-012 i_halt_id  in  1  instruction in IF/ID is HALT.
REQ-013 o_pipe_enable  out  1  global stage enable for all pipeline registers and PC.
REQ-014 o_pc_write  out  1  PC load enable.
REQ-015 o_ifid_write  out  1  IF/ID register load enable.
REQ-016 o_ifid_flush  out  1  IF/ID loads a NOP (0x00000000).
REQ-017 o_idex_bubble  out  1  ID/EX loads zero control (bubble).
REQ-018 o_state  out  3  current FSM state encoding.
REQ-019 o_halted  out  1  1 while in DONE.
REQ-020 o_cycle_count  out  CYCLE_WIDTH  enabled cycles since reset.

Function
REQ-021 FSM states SHALL be IDLE=000, RUN=001, STEP=010, DRAIN=011, DONE=100; state, drain counter, step-edge register and cycle counter registered; all other outputs combinational from state and inputs.
REQ-022 IDLE: o_pipe_enable=0; i_start=1 -> RUN if i_run_mode=1, else STEP.
REQ-023 RUN: o_pipe_enable=1 every cycle.
REQ-024 STEP: o_pipe_enable=1 for exactly one cycle per i_step rising edge (i_step=1 and previous-cycle i_step=0); held-high i_step gives one cycle only.
REQ-025 Load-use hazard H = i_idex_memread & (i_idex_rt!=0) & (i_idex_rt==i_ifid_rs | i_idex_rt==i_ifid_rt).
REQ-026 In RUN/STEP with enable=1 and H=1: o_pc_write=0, o_ifid_write=0, o_idex_bubble=1, o_ifid_flush=0.
REQ-027 In RUN/STEP with enable=1, H=0, i_branch_taken=1: o_pc_write=1, o_ifid_write=1, o_ifid_flush=1, o_idex_bubble=0.
REQ-028 H has priority over i_branch_taken and i_halt_id (branch/halt re-evaluated after stall).
REQ-029 In RUN/STEP with enable=1, H=0, i_halt_id=1: o_pc_write=0, o_ifid_write=0, o_ifid_flush=0, o_idex_bubble=0; next state DRAIN, drain counter loaded 3; i_halt_id has priority over i_branch_taken.
REQ-030 Otherwise with enable=1: o_pc_write=1, o_ifid_write=1, o_ifid_flush=0, o_idex_bubble=0.
REQ-031 Whenever o_pipe_enable=0: o_pc_write, o_ifid_write, o_ifid_flush, o_idex_bubble all 0.
REQ-032 DRAIN: enable generated as in RUN or STEP per mode captured at start; o_pc_write=0, o_ifid_write=0, o_idex_bubble=1; counter decrements per enabled cycle; enabled cycle with counter=1 -> DONE.
REQ-033 DONE: o_pipe_enable=0, o_halted=1; sticky until reset; i_start/i_step ignored.
REQ-034 o_cycle_count increments on every enabled cycle; saturates at all-ones (no wrap).

Reset
REQ-035 i_reset=0 SHALL force state IDLE, drain counter 0, step-edge register 0, o_cycle_count 0, hence all control outputs 0 and o_halted=0, including mid-DRAIN or mid-stall.
REQ-036 After reset release, first state change SHALL occur no earlier than the first posedge with i_reset=1.

Verification
REQ-037 Reset, i_run_mode=1, i_start=1 one cycle -> o_state=001, o_pipe_enable=1, o_pc_write=o_ifid_write=1, o_cycle_count increments 1/cycle.
REQ-038 RUN, i_idex_memread=1, i_idex_rt=5, i_ifid_rs=5 -> o_pc_write=0, o_ifid_write=0, o_idex_bubble=1; with i_idex_rt=0 -> no stall.
REQ-039 RUN, i_branch_taken=1 with H=1 -> stall only, o_ifid_flush=0; with H=0 -> o_ifid_flush=1.
REQ-040 STEP mode, i_step held high 5 cycles -> exactly one enabled cycle, o_cycle_count +1; second rising edge -> +1 again.
REQ-041 RUN, i_halt_id=1 -> DRAIN for 3 enabled cycles, then o_state=100, o_halted=1, o_cycle_count frozen; i_start afterwards -> no change.
REQ-042 i_reset=0 asserted mid-DRAIN between clock edges -> outputs zero immediately, o_state=000, o_cycle_count=0.
